// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared constants for the data memory responder: data width,
//                MMIO address map, register offsets, CTRL/STATUS bit
//                positions, register-select encoding and a byte-lane merge
//                helper used by every writable storage element.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam int XLEN = 32;

    // MMIO window and register byte offsets within it
    localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;
    localparam logic [7:0]  OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0]  OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0]  OFF_COUNT    = 8'h08;
    localparam logic [7:0]  OFF_COMPARE  = 8'h0C;
    localparam logic [7:0]  OFF_CTRL     = 8'h10;
    localparam logic [7:0]  OFF_STATUS   = 8'h14;

    // CTRL / STATUS bit positions
    localparam int CTRL_TIMER_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int STATUS_MATCH_BIT  = 0;

    localparam logic [XLEN-1:0] COMPARE_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        REG_GPIO_OUT = 3'd0,
        REG_GPIO_IN  = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_CTRL     = 3'd4,
        REG_STATUS   = 3'd5,
        REG_NONE     = 3'd7
    } mmio_reg_e;

    // Decode a word index (byte address >> 2) into an MMIO register.
    function automatic mmio_reg_e mmio_decode(input logic [29:0] word_idx);
        mmio_reg_e sel;
        sel = REG_NONE;
        if (word_idx[29:3] == MMIO_BASE[31:5]) begin
            case (word_idx[2:0])
                OFF_GPIO_OUT[4:2]: sel = REG_GPIO_OUT;
                OFF_GPIO_IN[4:2]:  sel = REG_GPIO_IN;
                OFF_COUNT[4:2]:    sel = REG_COUNT;
                OFF_COMPARE[4:2]:  sel = REG_COMPARE;
                OFF_CTRL[4:2]:     sel = REG_CTRL;
                OFF_STATUS[4:2]:   sel = REG_STATUS;
                default:           sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

    // Replace the byte lanes of old_val selected by mask with new_val.
    function automatic logic [XLEN-1:0] byte_merge(
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] new_val,
        input logic [3:0]      mask
    );
        logic [XLEN-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_timer
//  Description : Free-running compare timer with COUNT, COMPARE, CTRL and
//                STATUS registers plus a registered interrupt request.
//  Ports       : clk, resetN        - clock, async active-low reset
//                wr_count/compare/ctrl/status - qualified register writes
//                wr_data, wr_mask   - write data and byte-lane mask
//                rd_count/compare/ctrl/status - register read values
//                irq                - STATUS.match & CTRL.irq_en, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import data_mem_responder_pkg::*;
(
    input  logic            clk,
    input  logic            resetN,
    input  logic            wr_count,
    input  logic            wr_compare,
    input  logic            wr_ctrl,
    input  logic            wr_status,
    input  logic [XLEN-1:0] wr_data,
    input  logic [3:0]      wr_mask,
    output logic [XLEN-1:0] rd_count,
    output logic [XLEN-1:0] rd_compare,
    output logic [XLEN-1:0] rd_ctrl,
    output logic [XLEN-1:0] rd_status,
    output logic            irq
);

    logic [XLEN-1:0] count_q,   count_d;
    logic [XLEN-1:0] compare_q, compare_d;
    logic [1:0]      ctrl_q,    ctrl_d;
    logic            status_q,  status_d;
    logic            irq_q,     irq_d;

    logic [XLEN-1:0] count_inc;
    logic            match;
    logic            clear;

    always_comb begin
        count_inc = count_q;
        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        match     = 1'b0;
        clear     = 1'b0;
        status_d  = status_q;
        irq_d     = 1'b0;

        // Wraps naturally at the top of the range.
        if (ctrl_q[CTRL_TIMER_EN_BIT]) begin
            count_inc = count_q + 32'd1;
        end

        // Written lanes take the CPU value, untouched lanes keep counting.
        count_d = wr_count ? byte_merge(count_inc, wr_data, wr_mask) : count_inc;

        if (wr_compare) begin
            compare_d = byte_merge(compare_q, wr_data, wr_mask);
        end

        // CTRL bits live entirely in byte lane 0.
        if (wr_ctrl && wr_mask[0]) begin
            ctrl_d = wr_data[1:0];
        end

        match = ctrl_q[CTRL_TIMER_EN_BIT] && (count_q == compare_q);
        clear = wr_status && wr_mask[0] && wr_data[STATUS_MATCH_BIT];

        // A match in the same cycle as a clear keeps the flag set.
        status_d = match | (status_q & ~clear);

        irq_d = status_q & ctrl_q[CTRL_IRQ_EN_BIT];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q   <= '0;
            compare_q <= COMPARE_RESET;
            ctrl_q    <= '0;
            status_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_count   = count_q;
    assign rd_compare = compare_q;
    assign rd_ctrl    = {30'd0, ctrl_q};
    assign rd_status  = {31'd0, status_q};
    assign irq        = irq_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data-side memory for a single-cycle CPU: byte-enabled RAM
//                with combinational read, GPIO registers and a compare timer
//                mapped at 0xFFFF_0000. Unmapped accesses raise fault.
//  Ports       : clk, resetN  - clock, async active-low reset
//                memAddr      - CPU byte address (bits 1:0 ignored)
//                memIn, memWr, wrMask - lane-shifted write data, enable, mask
//                memOut       - aligned word read data (combinational)
//                gpioIn/gpioOut - GPIO pins
//                irq          - timer interrupt (registered)
//                fault        - unmapped address (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [XLEN-1:0]   memAddr,
    input  logic [XLEN-1:0]   memIn,
    input  logic              memWr,
    input  logic [3:0]        wrMask,
    output logic [XLEN-1:0]   memOut,
    input  logic [GPIO_W-1:0] gpioIn,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              irq,
    output logic              fault
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    mmio_reg_e     mmio_sel;
    logic          mmio_hit;
    logic          unused_addr_bits;

    assign word_idx         = memAddr[31:2];
    assign ram_idx          = memAddr[AW+1:2];
    assign ram_hit          = ({2'b00, word_idx} < RAM_LIMIT);
    assign mmio_sel         = mmio_decode(word_idx);
    assign mmio_hit         = (mmio_sel != REG_NONE);
    assign fault            = ~ram_hit & ~mmio_hit;
    assign unused_addr_bits = ^memAddr[1:0];

    // ------------------------------------------------------------------
    // RAM: no reset so it maps onto block RAM with byte write enables
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ram_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (memWr && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wrMask[i]) begin
                    ram_mem[ram_idx][8*i +: 8] <= memIn[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // GPIO output register
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (memWr && (mmio_sel == REG_GPIO_OUT)) begin
            for (int b = 0; b < GPIO_W; b++) begin
                if (wrMask[b/8]) begin
                    gpio_out_d[b] = memIn[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gpio_out_q <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
        end
    end

    assign gpioOut = gpio_out_q;

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rd_count;
    logic [XLEN-1:0] rd_compare;
    logic [XLEN-1:0] rd_ctrl;
    logic [XLEN-1:0] rd_status;

    mmio_timer u_timer (
        .clk        (clk),
        .resetN     (resetN),
        .wr_count   (memWr && (mmio_sel == REG_COUNT)),
        .wr_compare (memWr && (mmio_sel == REG_COMPARE)),
        .wr_ctrl    (memWr && (mmio_sel == REG_CTRL)),
        .wr_status  (memWr && (mmio_sel == REG_STATUS)),
        .wr_data    (memIn),
        .wr_mask    (wrMask),
        .rd_count   (rd_count),
        .rd_compare (rd_compare),
        .rd_ctrl    (rd_ctrl),
        .rd_status  (rd_status),
        .irq        (irq)
    );

    // ------------------------------------------------------------------
    // Read mux; unmapped addresses read as zero
    // ------------------------------------------------------------------
    always_comb begin
        memOut = '0;
        if (ram_hit) begin
            memOut = ram_mem[ram_idx];
        end else begin
            case (mmio_sel)
                REG_GPIO_OUT: memOut = 32'(gpio_out_q);
                REG_GPIO_IN:  memOut = 32'(gpioIn);
                REG_COUNT:    memOut = rd_count;
                REG_COMPARE:  memOut = rd_compare;
                REG_CTRL:     memOut = rd_ctrl;
                REG_STATUS:   memOut = rd_status;
                default:      memOut = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
    localparam logic [31:0] A_COUNT    = 32'hFFFF_0008;
    localparam logic [31:0] A_COMPARE  = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL     = 32'hFFFF_0010;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_0014;

    logic        clk;
    logic        resetN;
    logic [31:0] memAddr;
    logic [31:0] memIn;
    logic        memWr;
    logic [3:0]  wrMask;
    logic [31:0] memOut;
    logic [7:0]  gpioIn;
    logic [7:0]  gpioOut;
    logic        irq;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(.RAM_WORDS(1024), .GPIO_W(8)) dut (
        .clk     (clk),
        .resetN  (resetN),
        .memAddr (memAddr),
        .memIn   (memIn),
        .memWr   (memWr),
        .wrMask  (wrMask),
        .memOut  (memOut),
        .gpioIn  (gpioIn),
        .gpioOut (gpioOut),
        .irq     (irq),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        memAddr = a;
        memIn   = d;
        wrMask  = m;
        memWr   = 1'b1;
        @(posedge clk);
        #1;
        memWr   = 1'b0;
        wrMask  = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic f);
        memWr   = 1'b0;
        memAddr = a;
        #1;
        d = memOut;
        f = fault;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        f;
        #12;
        n_checks++; if (gpioOut !== 8'h00) begin n_fail++; $display("FAIL reset_gpio: got %h want 00", gpioOut); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", d); end
        bus_read(A_COMPARE, d, f);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_compare: got %h want ffffffff", d); end
        bus_read(A_CTRL, d, f);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(A_STATUS, d, f);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_ram();
        logic [31:0] d;
        logic        f;
        bus_write(32'h10, 32'hAABB_CCDD, 4'b1111);
        bus_write(32'h12, 32'h0011_0000, 4'b0100);
        bus_read(32'h10, d, f);
        n_checks++; if (d !== 32'hAA11_CCDD || f !== 1'b0) begin n_fail++; $display("FAIL ram_lane_merge: got %h/%b want aa11ccdd/0", d, f); end
        bus_read(32'h13, d, f);
        n_checks++; if (d !== 32'hAA11_CCDD) begin n_fail++; $display("FAIL ram_unaligned_read: got %h want aa11ccdd", d); end
        bus_write(32'hFFC, 32'h1357_9BDF, 4'b1111);
        bus_read(32'hFFC, d, f);
        n_checks++; if (d !== 32'h1357_9BDF || f !== 1'b0) begin n_fail++; $display("FAIL ram_top_word: got %h/%b want 13579bdf/0", d, f); end
        bus_read(32'h1000, d, f);
        n_checks++; if (d !== 32'h0 || f !== 1'b1) begin n_fail++; $display("FAIL ram_past_end: got %h/%b want 0/1", d, f); end
    endtask

    task automatic test_gpio();
        logic [31:0] d;
        logic        f;
        bus_write(A_GPIO_OUT, 32'h0000_005A, 4'b1111);
        n_checks++; if (gpioOut !== 8'h5A) begin n_fail++; $display("FAIL gpio_out_pins: got %h want 5a", gpioOut); end
        bus_write(A_GPIO_OUT, 32'hFFFF_FFFF, 4'b1110);
        bus_read(A_GPIO_OUT, d, f);
        n_checks++; if (d !== 32'h0000_005A || f !== 1'b0) begin n_fail++; $display("FAIL gpio_out_masked: got %h/%b want 0000005a/0", d, f); end
        gpioIn = 8'hC3;
        bus_read(A_GPIO_IN, d, f);
        n_checks++; if (d !== 32'h0000_00C3) begin n_fail++; $display("FAIL gpio_in_read: got %h want 000000c3", d); end
        bus_write(A_CTRL, 32'hFFFF_FFFC, 4'b1111);
        bus_read(A_CTRL, d, f);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_unimpl_bits: got %h want 0", d); end
    endtask

    task automatic test_fault();
        logic [31:0] d;
        logic        f;
        bus_write(32'h0, 32'h0123_4567, 4'b1111);
        bus_read(32'h8000_0000, d, f);
        n_checks++; if (d !== 32'h0 || f !== 1'b1) begin n_fail++; $display("FAIL fault_read: got %h/%b want 0/1", d, f); end
        bus_write(32'h8000_0000, 32'hDEAD_BEEF, 4'b1111);
        bus_write(32'hFFFE_0000, 32'h0000_00FF, 4'b1111);
        bus_write(32'hFFFF_0018, 32'h0000_0000, 4'b1111);
        bus_read(32'h0, d, f);
        n_checks++; if (d !== 32'h0123_4567) begin n_fail++; $display("FAIL fault_ram0_kept: got %h want 01234567", d); end
        bus_read(32'h10, d, f);
        n_checks++; if (d !== 32'hAA11_CCDD) begin n_fail++; $display("FAIL fault_ram10_kept: got %h want aa11ccdd", d); end
        n_checks++; if (gpioOut !== 8'h5A) begin n_fail++; $display("FAIL fault_gpio_kept: got %h want 5a", gpioOut); end
        bus_read(A_COMPARE, d, f);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fault_compare_kept: got %h want ffffffff", d); end
        bus_read(32'hFFFF_0018, d, f);
        n_checks++; if (f !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL fault_mmio_hole: got %h/%b want 0/1", d, f); end
    endtask

    task automatic test_timer_irq();
        logic [31:0] d;
        logic        f;
        bus_write(A_COMPARE, 32'd5, 4'b1111);
        bus_write(A_COUNT, 32'd0, 4'b1111);
        bus_write(A_CTRL, 32'd3, 4'b1111);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            bus_read(A_COUNT, d, f);
            n_checks++; if (d !== 32'(k)) begin n_fail++; $display("FAIL timer_count[%0d]: got %h want %h", k, d, 32'(k)); end
            bus_read(A_STATUS, d, f);
            n_checks++; if (d !== ((k >= 6) ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL timer_status[%0d]: got %h want %0d", k, d, (k >= 6) ? 1 : 0); end
            n_checks++; if (irq !== ((k >= 7) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL timer_irq[%0d]: got %b want %0d", k, irq, (k >= 7) ? 1 : 0); end
        end
        bus_write(A_STATUS, 32'd1, 4'b0001);
        bus_read(A_STATUS, d, f);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL w1c_status: got %h want 0", d); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_lag: got %b want 1", irq); end
        @(posedge clk);
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_drop: got %b want 0", irq); end
        bus_write(A_CTRL, 32'd0, 4'b1111);
    endtask

    task automatic test_count_wrap();
        logic [31:0] d;
        logic        f;
        bus_write(A_COMPARE, 32'h10, 4'b1111);
        bus_write(A_COUNT, 32'hFFFF_FFFE, 4'b1111);
        bus_write(A_CTRL, 32'd1, 4'b1111);
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_start: got %h want fffffffe", d); end
        @(posedge clk); #1;
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffffffff", d); end
        @(posedge clk); #1;
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", d); end
        @(posedge clk); #1;
        bus_read(A_STATUS, d, f);
        n_checks++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL wrap_no_flag: got %h/%b want 0/0", d, irq); end
        bus_write(A_CTRL, 32'd0, 4'b1111);
    endtask

    task automatic test_count_write_merge();
        logic [31:0] d;
        logic        f;
        bus_write(A_COUNT, 32'h0000_01FF, 4'b1111);
        bus_write(A_CTRL, 32'd1, 4'b1111);
        bus_write(A_COUNT, 32'h0000_0055, 4'b0001);
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'h0000_0255) begin n_fail++; $display("FAIL count_merge: got %h want 00000255", d); end
        @(posedge clk); #1;
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'h0000_0256) begin n_fail++; $display("FAIL count_merge_next: got %h want 00000256", d); end
        bus_write(A_CTRL, 32'd0, 4'b1111);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        logic        f;
        bus_write(A_COMPARE, 32'h20, 4'b1111);
        bus_write(A_COUNT, 32'h1E, 4'b1111);
        bus_write(A_CTRL, 32'd1, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_read(A_COUNT, d, f);
        n_checks++; if (d !== 32'h20) begin n_fail++; $display("FAIL setwin_align: got %h want 00000020", d); end
        bus_write(A_STATUS, 32'd1, 4'b0001);
        bus_read(A_STATUS, d, f);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL setwin_status: got %h want 1", d); end
        bus_write(A_CTRL, 32'd0, 4'b1111);
        bus_write(A_STATUS, 32'd1, 4'b0001);
        bus_read(A_STATUS, d, f);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL setwin_cleanup: got %h want 0", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        f;
        bus_write(A_GPIO_OUT, 32'h5A, 4'b1111);
        bus_write(A_COMPARE, 32'h1234, 4'b1111);
        bus_write(A_CTRL, 32'd2, 4'b1111);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        n_checks++; if (gpioOut !== 8'h00) begin n_fail++; $display("FAIL async_gpio: got %h want 00", gpioOut); end
        bus_read(A_COMPARE, d, f);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL async_compare: got %h want ffffffff", d); end
        bus_read(A_CTRL, d, f);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL async_ctrl: got %h want 0", d); end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN  = 1'b0;
        memAddr = 32'h0;
        memIn   = 32'h0;
        memWr   = 1'b0;
        wrMask  = 4'h0;
        gpioIn  = 8'h00;

        test_reset();
        test_ram();
        test_gpio();
        test_fault();
        test_timer_irq();
        test_count_wrap();
        test_count_write_merge();
        test_set_wins();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, is the number of 32-bit RAM words (power of two).
REQ-002 Parameter GPIO_W, default 8, is the GPIO width in bits (1..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 memAddr  input  32  byte address from the CPU.
REQ-006 memIn  input  32  write data, already lane-shifted by the CPU.
REQ-007 memWr  input  1  write enable.
REQ-008 wrMask  input  4  byte-lane write mask; bit i enables memIn[8i+7:8i].
REQ-009 memOut  output  32  read data for the full aligned word at memAddr.
REQ-010 gpioIn  input  GPIO_W  external input pins.
REQ-011 gpioOut  output  GPIO_W  registered output pins.
REQ-012 irq  output  1  timer interrupt request, registered.
REQ-013 fault  output  1  combinational; high when memAddr is unmapped.

Function
REQ-014 Word index = memAddr[31:2]; memAddr[1:0] SHALL be ignored for both decode and data.
REQ-015 RAM region: memAddr < 4*RAM_WORDS.
REQ-016 MMIO region: 0xFFFF_0000 GPIO_OUT (rw), 0xFFFF_0004 GPIO_IN (ro), 0xFFFF_0008 COUNT (rw), 0xFFFF_000C COMPARE (rw), 0xFFFF_0010 CTRL (rw; bit0 timer enable, bit1 irq enable), 0xFFFF_0014 STATUS (bit0 match flag, write-1-to-clear).
REQ-017 Any other address SHALL assert fault, read as 0, and ignore writes.
REQ-018 Reads SHALL be combinational with zero-cycle latency, so the single-cycle CPU sees memOut in the same cycle.
REQ-019 Writes SHALL take effect at the rising edge where memWr=1, and only on lanes whose wrMask bit is set.
REQ-020 The byte-mask rule SHALL apply equally to RAM and to writable MMIO registers.
REQ-021 Unimplemented MMIO bits SHALL read 0; GPIO_IN SHALL read gpioIn zero-extended (unsynchronised; the pins are quasi-static).
REQ-022 When CTRL.bit0=1, COUNT SHALL increment by 1 per cycle, wrapping from 0xFFFF_FFFF to 0 with no side effect.
REQ-023 A CPU write to COUNT in the same cycle as an increment: the written lanes take the written value, all other lanes take the incremented value.
REQ-024 When CTRL.bit0=1 and COUNT==COMPARE, STATUS.bit0 SHALL be set at the next edge.
REQ-025 If a W1C clear and a match-set occur in the same cycle, set SHALL win.
REQ-026 irq SHALL be registered as STATUS.bit0 & CTRL.bit1, i.e. one cycle after the flag.
REQ-027 A read SHALL have no side effects on any state.

Reset
REQ-028 While resetN=0: gpioOut=0, COUNT=0, COMPARE=0xFFFF_FFFF, CTRL=0, STATUS=0, irq=0.
REQ-029 RAM contents SHALL NOT be reset and are undefined after power-up.
REQ-030 Reset asserted mid-write SHALL drop the write to MMIO registers; a RAM write in that cycle is undefined.

Structure
REQ-031 The address map bases, register offsets and CTRL/STATUS bit positions SHALL live in the shared constants header alongside XLEN.
REQ-032 The timer (COUNT, COMPARE, CTRL, STATUS, irq) SHALL be a sub-module named mmio_timer; the RAM SHALL remain inline and be inferable as block RAM with byte enables.

Verification
REQ-033 Write 0xAABBCCDD to 0x10 with mask 1111, then 0x11 to 0x12 with mask 0100 -> read 0x10 returns 0xAA11CCDD.
REQ-034 Read 0x8000_0000 -> fault=1, memOut=0; write to the same address -> all RAM and MMIO unchanged.
REQ-035 COMPARE=5, CTRL=3, COUNT=0 -> STATUS.bit0 sets one edge after COUNT==5, irq one edge later; W1C on STATUS -> irq drops next edge.
REQ-036 COUNT=0xFFFF_FFFE, enabled -> reads 0xFFFF_FFFF, then 0; no flag with COMPARE=0x10.
REQ-037 Write GPIO_OUT=0x5A, pulse resetN low asynchronously between edges -> gpioOut=0 immediately, COMPARE=0xFFFF_FFFF.
REQ-038 Match-set and W1C on STATUS in the same cycle -> STATUS.bit0=1 afterwards.
